// File: rtl/fourbits_pkg.sv
// Shared types and constants for the fourbits program-store dump path.
// Imported by the transmitter and its baud sub-module.
package fourbits_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   localparam logic [7:0] DUMP_HDR   = 8'hA5;
   localparam int         FRAME_BITS = 10;

endpackage

// File: rtl/prog_dump_tx_if.sv
// Control, program-store read port and serial line of prog_dump_tx.
// slave is the transmitter side, master is the host/store side.
interface prog_dump_tx_if #(
   parameter int INSTR_W = 5
);

   logic               start;
   logic [3:0]         rd_addr;
   logic [INSTR_W-1:0] rd_data;
   logic               tx;
   logic               busy;
   logic               done;

   modport master (
      output start,
      output rd_data,
      input  rd_addr,
      input  tx,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  rd_data,
      output rd_addr,
      output tx,
      output busy,
      output done
   );

endinterface

// File: rtl/prog_dump_tx_baud_tick.sv
// Modulo-CLKS_PER_BIT bit timer with synchronous restart.
// tick is high on the last cycle of each bit period.
module baud_tick #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic clear,
   input  logic restart,
   output logic tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (restart || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/prog_dump_tx.sv
// Program-store readback transmitter: header 8'hA5 then one byte
// per store entry, 8N1 framing, frames sent back to back.
module prog_dump_tx
   import fourbits_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DEPTH        = 16,
   parameter int INSTR_W      = 5
) (
   input logic           clk,
   input logic           clear,
   prog_dump_tx_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH);

   state_t             state_q;
   state_t             state_d;
   logic [7:0]         sh_q;
   logic [7:0]         sh_d;
   logic [2:0]         bit_q;
   logic [2:0]         bit_d;
   logic [IDX_W-1:0]   idx_q;
   logic [IDX_W-1:0]   idx_d;
   logic [3:0]         addr_q;
   logic [3:0]         addr_d;
   logic               done_q;
   logic               done_d;
   logic               tick;
   logic               restart;
   logic               tx_bit;
   logic [INSTR_W-1:0] instr;

   assign instr = bus.rd_data;

   // Counter held at zero in IDLE and cleared on every state change.
   assign restart = (state_q == IDLE) || (state_d != state_q);

   baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk    (clk),
      .clear  (clear),
      .restart(restart),
      .tick   (tick)
   );

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      bit_d   = bit_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = START;
               sh_d    = DUMP_HDR;
               idx_d   = '0;
               bit_d   = '0;
               addr_d  = '0;
            end
         end
         START: begin
            if (tick) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (tick) begin
               sh_d  = {1'b0, sh_q[7:1]};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  // Advance early so rd_data settles for a full stop bit.
                  if (idx_q != '0 && idx_q != LAST_IDX) begin
                     addr_d = addr_q + 4'd1;
                  end
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  addr_d  = '0;
               end else begin
                  state_d = START;
                  idx_d   = idx_q + IDX_W'(1);
                  sh_d    = 8'(instr);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      tx_bit = 1'b1;
      unique case (state_q)
         START:   tx_bit = 1'b0;
         DATA:    tx_bit = sh_q[0];
         default: tx_bit = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q <= IDLE;
         sh_q    <= '0;
         bit_q   <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         bit_q   <= bit_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
      end
   end

   assign bus.tx      = tx_bit;
   assign bus.busy    = (state_q != IDLE);
   assign bus.done    = done_q;
   assign bus.rd_addr = addr_q;

endmodule

// File: tb/tb_prog_dump_tx.sv
// Scoreboard bench for prog_dump_tx: a UART monitor decodes tx and
// compares each byte against the queue filled when a dump is started.
module tb_prog_dump_tx;
   import fourbits_pkg::*;

   localparam int CPB   = 4;
   localparam int DEP   = 16;
   localparam int FCYC  = FRAME_BITS * CPB;
   localparam int TOTAL = (DEP + 1) * FCYC;

   logic clk = 1'b0;
   logic clear;
   logic [4:0] mem [DEP];

   int n_tests = 0;
   int n_fail  = 0;
   int n_bytes = 0;

   logic [7:0] exp_q [$];

   prog_dump_tx_if #(.INSTR_W(5)) bus ();

   prog_dump_tx #(
      .CLKS_PER_BIT(CPB),
      .DEPTH       (DEP),
      .INSTR_W     (5)
   ) dut (
      .clk  (clk),
      .clear(clear),
      .bus  (bus)
   );

   assign bus.rd_data = mem[bus.rd_addr];

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // UART monitor: sample each bit in its middle cycle.
   bit         mon_on = 1'b0;
   int         mcnt   = 0;
   logic [7:0] mbyte  = '0;

   always @(negedge clk) begin
      if (!clear) begin
         mon_on = 1'b0;
      end else if (!mon_on) begin
         if (bus.tx == 1'b0) begin
            mon_on = 1'b1;
            mcnt   = 0;
            mbyte  = '0;
         end
      end else begin
         mcnt++;
         if (mcnt == 2) begin
            check("start_bit", int'(bus.tx), 0);
         end else if (mcnt % 4 == 2 && mcnt >= 6 && mcnt <= 34) begin
            mbyte = {bus.tx, mbyte[7:1]};
         end else if (mcnt == 38) begin
            check("stop_bit", int'(bus.tx), 1);
            n_bytes++;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL extra_byte: got 0x%0h, want none", mbyte);
            end else begin
               check($sformatf("byte%0d", n_bytes), int'(mbyte),
                     int'(exp_q.pop_front()));
            end
            mon_on = 1'b0;
         end
      end
   end

   task automatic idle_check(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("idle_tx", int'(bus.tx), 1);
         check("idle_busy", int'(bus.busy), 0);
         check("idle_done", int'(bus.done), 0);
         check("idle_addr", int'(bus.rd_addr), 0);
      end
   endtask

   task automatic do_dump(input bit poke, input int abort_at);
      int   busy_bad;
      int   done_cnt;
      int   chg_cnt;
      int   b0;
      logic [3:0] prev;
      logic [3:0] nxt;
      bit   aborted;
      busy_bad = 0;
      done_cnt = 0;
      chg_cnt  = 0;
      prev     = 4'd0;
      nxt      = 4'd1;
      aborted  = 1'b0;
      b0       = n_bytes;
      exp_q.push_back(8'hA5);
      for (int k = 0; k < DEP; k++) begin
         exp_q.push_back({3'b000, mem[k]});
      end
      @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int cyc = 1; cyc <= TOTAL + 20; cyc++) begin
         @(negedge clk);
         if (cyc == 1) check("tx_latency", int'(bus.tx), 0);
         if (cyc <= TOTAL && !bus.busy) busy_bad++;
         if (bus.done) done_cnt++;
         if (cyc == TOTAL + 1) begin
            check("done_at_681", int'(bus.done), 1);
            check("busy_end", int'(bus.busy), 0);
            check("addr_end", int'(bus.rd_addr), 0);
         end
         if (bus.rd_addr != prev) begin
            chg_cnt++;
            check("addr_step", int'(bus.rd_addr), int'(nxt));
            if (bus.rd_addr != 4'd0) begin
               check("addr_cycle", cyc, 40 * int'(bus.rd_addr) + 37);
            end else begin
               check("addr_ret_cycle", cyc, TOTAL + 1);
            end
            prev = bus.rd_addr;
            nxt  = bus.rd_addr + 4'd1;
         end
         if (poke) bus.start = (cyc == 100 || cyc == 300);
         if (cyc == abort_at) begin
            clear = 1'b0;
            #1;
            check("rst_tx", int'(bus.tx), 1);
            check("rst_busy", int'(bus.busy), 0);
            check("rst_done", int'(bus.done), 0);
            check("rst_addr", int'(bus.rd_addr), 0);
            repeat (3) @(negedge clk);
            clear = 1'b1;
            exp_q.delete();
            aborted = 1'b1;
            break;
         end
      end
      bus.start = 1'b0;
      if (!aborted) begin
         check("busy_window", busy_bad, 0);
         check("done_count", done_cnt, 1);
         check("addr_changes", chg_cnt, DEP);
         check("byte_count", n_bytes - b0, DEP + 1);
         check("queue_empty", exp_q.size(), 0);
      end
   endtask

   initial begin
      clear     = 1'b0;
      bus.start = 1'b0;
      for (int i = 0; i < DEP; i++) mem[i] = 5'(i + 1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      clear = 1'b1;
      idle_check(20);
      do_dump(1'b0, 0);
      idle_check(5);
      do_dump(1'b1, 0);
      idle_check(5);
      do_dump(1'b0, 250);
      idle_check(5);
      do_dump(1'b0, 0);
      for (int i = 0; i < DEP; i++) mem[i] = 5'h1F;
      idle_check(5);
      do_dump(1'b0, 0);
      idle_check(5);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
